// File: rtl/altera_tse_gxb_aligned_txsync_if.sv
// -----------------------------------------------------------------------------
// altera_tse_gxb_aligned_txsync_if
// Bundles the PCS-side transmit inputs and the GXB-side outputs of the
// transmit alignment conditioner.
//   master : PCS encoder / status consumer (drives pcs_*, alt_tx_ready)
//   slave  : altera_tse_gxb_aligned_txsync (drives alt_*, tx_* outputs)
// Parameter ERR_CNT_W must match the conditioner's ERR_CNT_W.
// -----------------------------------------------------------------------------
interface altera_tse_gxb_aligned_txsync_if #(
  parameter int ERR_CNT_W = 8
);
  logic [7:0]           pcs_txdata;
  logic                 pcs_txctrl;
  logic                 alt_tx_ready;
  logic [7:0]           alt_txdata;
  logic                 alt_txctrl;
  logic                 alt_forcedisp;
  logic                 alt_dispval;
  logic                 tx_aligned;
  logic [ERR_CNT_W-1:0] tx_misalign_cnt;

  modport master (
    output pcs_txdata, pcs_txctrl, alt_tx_ready,
    input  alt_txdata, alt_txctrl, alt_forcedisp, alt_dispval,
           tx_aligned, tx_misalign_cnt
  );

  modport slave (
    input  pcs_txdata, pcs_txctrl, alt_tx_ready,
    output alt_txdata, alt_txctrl, alt_forcedisp, alt_dispval,
           tx_aligned, tx_misalign_cnt
  );
endinterface

// File: rtl/altera_tse_gxb_aligned_txsync.sv
// -----------------------------------------------------------------------------
// altera_tse_gxb_aligned_txsync
// Transmit-side conditioner between the 1000BASE-X PCS encoder and the GXB
// transmitter. Holds the lane quiet until the transceiver is ready, emits
// /I2/ idles (K28.5, D16.2) from an even code-group slot, then passes PCS
// data once the PCS stream offers K28.5 on an even slot after IDLE_PAIRS
// idle pairs. A K28.5 on an odd slot in PASS is replaced by D16.2, counted,
// and triggers realignment.
//
// Ports:
//   clk    : transmit parallel clock
//   reset  : synchronous, active-high reset
//   bus    : slave modport of altera_tse_gxb_aligned_txsync_if
//            (pcs_txdata/pcs_txctrl/alt_tx_ready in; alt_txdata, alt_txctrl,
//             alt_forcedisp, alt_dispval, tx_aligned, tx_misalign_cnt out)
//
// Output latency LAT is 1 for STRATIXIIGX/ARRIAGX, otherwise 2.
//
// Optional feature macro: TSE_TXSYNC_DISPFORCE_EN
//   When defined, the first K28.5 of every ALIGN entry forces RD- through
//   alt_forcedisp/alt_dispval. When undefined both outputs are tied to 0.
// -----------------------------------------------------------------------------
module altera_tse_gxb_aligned_txsync #(
  parameter string DEVICE_FAMILY = "CYCLONEV",
  parameter int    IDLE_PAIRS    = 8,
  parameter int    ERR_CNT_W     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  altera_tse_gxb_aligned_txsync_if.slave     bus
);

  localparam int LAT = ((DEVICE_FAMILY == "STRATIXIIGX") ||
                        (DEVICE_FAMILY == "ARRIAGX")) ? 1 : 2;

  localparam logic [1:0] ST_WAIT_READY = 2'd0;
  localparam logic [1:0] ST_ALIGN      = 2'd1;
  localparam logic [1:0] ST_PASS       = 2'd2;

  localparam logic [7:0] K28_5     = 8'hBC;
  localparam logic [7:0] D16_2     = 8'h50;
  localparam logic [7:0] IDLE_GOAL = IDLE_PAIRS[7:0];
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [7:0] data;
    logic       ctrl;
    logic       aligned;
`ifdef TSE_TXSYNC_DISPFORCE_EN
    logic       fd;
    logic       dv;
`endif
  } stage_t;

  logic [1:0]           state_q, state_d;
  logic                 parity_q, parity_d;
  logic [7:0]           pair_q, pair_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 is_k285_s;
  stage_t               s0_s;
  stage_t               pipe_q [LAT];

  assign is_k285_s = bus.pcs_txctrl && (bus.pcs_txdata == K28_5);

  // Next-state, stage-0 word and counter updates.
  always_comb begin
    state_d  = state_q;
    parity_d = parity_q;
    pair_d   = pair_q;
    cnt_d    = cnt_q;
    s0_s     = '0;
    case (state_q)
      ST_WAIT_READY: begin
        // Parity stays 0 so the first ALIGN cycle is an even slot.
        parity_d = 1'b0;
        pair_d   = 8'd0;
        if (bus.alt_tx_ready) begin
          state_d = ST_ALIGN;
        end else begin
          state_d = ST_WAIT_READY;
        end
      end
      ST_ALIGN: begin
        parity_d  = ~parity_q;
        s0_s.data = parity_q ? D16_2 : K28_5;
        s0_s.ctrl = ~parity_q;
`ifdef TSE_TXSYNC_DISPFORCE_EN
        // Only the first K28.5 after entering ALIGN sees pair_q==0 on even.
        s0_s.fd   = ~parity_q & (pair_q == 8'd0);
`endif
        if (parity_q && (pair_q != IDLE_GOAL)) begin
          pair_d = pair_q + 8'd1;
        end else begin
          pair_d = pair_q;
        end
        // The K28.5 that opens PASS is itself the first passed byte.
        if (bus.alt_tx_ready && !parity_q && (pair_q == IDLE_GOAL) && is_k285_s) begin
          state_d      = ST_PASS;
          s0_s.data    = bus.pcs_txdata;
          s0_s.ctrl    = bus.pcs_txctrl;
          s0_s.aligned = 1'b1;
`ifdef TSE_TXSYNC_DISPFORCE_EN
          s0_s.fd      = 1'b0;
`endif
        end else begin
          state_d = ST_ALIGN;
        end
      end
      ST_PASS: begin
        parity_d     = ~parity_q;
        s0_s.data    = bus.pcs_txdata;
        s0_s.ctrl    = bus.pcs_txctrl;
        s0_s.aligned = 1'b1;
        // Odd-slot comma: suppress it and retrain; parity keeps running.
        if (bus.alt_tx_ready && parity_q && is_k285_s) begin
          s0_s.data    = D16_2;
          s0_s.ctrl    = 1'b0;
          s0_s.aligned = 1'b0;
          state_d      = ST_ALIGN;
          pair_d       = 8'd0;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          state_d = ST_PASS;
        end
      end
      default: begin
        state_d  = ST_WAIT_READY;
        parity_d = 1'b0;
        pair_d   = 8'd0;
      end
    endcase
    // Loss of readiness overrides every transition above.
    if (!bus.alt_tx_ready) begin
      state_d  = ST_WAIT_READY;
      parity_d = 1'b0;
      pair_d   = 8'd0;
    end else begin
      state_d  = state_d;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_WAIT_READY;
      parity_q <= 1'b0;
      pair_q   <= 8'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      parity_q <= parity_d;
      pair_q   <= pair_d;
      cnt_q    <= cnt_d;
    end
  end

  // Fixed-latency output pipeline; reset clears every stage at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= s0_s;
      for (int i = 1; i < LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign bus.alt_txdata      = pipe_q[LAT-1].data;
  assign bus.alt_txctrl      = pipe_q[LAT-1].ctrl;
  assign bus.tx_aligned      = pipe_q[LAT-1].aligned;
  assign bus.tx_misalign_cnt = cnt_q;
`ifdef TSE_TXSYNC_DISPFORCE_EN
  assign bus.alt_forcedisp   = pipe_q[LAT-1].fd;
  assign bus.alt_dispval     = pipe_q[LAT-1].dv;
`else
  assign bus.alt_forcedisp   = 1'b0;
  assign bus.alt_dispval     = 1'b0;
`endif

endmodule

// File: tb/tb_altera_tse_gxb_aligned_txsync.sv
// Directed bench for altera_tse_gxb_aligned_txsync. Two instances share the
// same stimulus: dut_a (CYCLONEV, 2-cycle latency) and dut_b (ARRIAGX,
// 1-cycle latency). Each task writes the hand-derived stage-0 word for the
// current cycle into e0; after each edge the expected outputs are e0 from
// one cycle back (dut_b) and two cycles back (dut_a).
module tb_altera_tse_gxb_aligned_txsync;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_cnt = 0;

`ifdef TSE_TXSYNC_DISPFORCE_EN
  localparam bit DISP_EN = 1'b1;
`else
  localparam bit DISP_EN = 1'b0;
`endif

  altera_tse_gxb_aligned_txsync_if #(.ERR_CNT_W(8)) bus_a ();
  altera_tse_gxb_aligned_txsync_if #(.ERR_CNT_W(8)) bus_b ();

  assign bus_b.pcs_txdata   = bus_a.pcs_txdata;
  assign bus_b.pcs_txctrl   = bus_a.pcs_txctrl;
  assign bus_b.alt_tx_ready = bus_a.alt_tx_ready;

  altera_tse_gxb_aligned_txsync #(.DEVICE_FAMILY("CYCLONEV"), .IDLE_PAIRS(8), .ERR_CNT_W(8))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  altera_tse_gxb_aligned_txsync #(.DEVICE_FAMILY("ARRIAGX"), .IDLE_PAIRS(8), .ERR_CNT_W(8))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;

  // {data[7:0], ctrl, aligned, forcedisp, dispval}
  logic [11:0] obs_a, obs_b;
  assign obs_a = {bus_a.alt_txdata, bus_a.alt_txctrl, bus_a.tx_aligned, bus_a.alt_forcedisp, bus_a.alt_dispval};
  assign obs_b = {bus_b.alt_txdata, bus_b.alt_txctrl, bus_b.tx_aligned, bus_b.alt_forcedisp, bus_b.alt_dispval};

  logic [11:0] e0, h1, h2;

  function automatic logic [11:0] word(input logic [7:0] d, input logic c, input logic al, input logic fd);
    return {d, c, al, fd, 1'b0};
  endfunction

  task automatic drive(input logic [7:0] d, input logic c);
    bus_a.pcs_txdata = d;
    bus_a.pcs_txctrl = c;
  endtask

  // Advance one clock; expected history follows the configured latencies.
  task automatic tick();
    if (reset) begin
      h1 = 12'h000;
      h2 = 12'h000;
    end else begin
      h2 = h1;
      h1 = e0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_a.alt_tx_ready = 1'b0;
    drive(8'h00, 1'b0);
    e0 = 12'h000;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(8'hBC, 1'b1);
      e0 = 12'h000;
      tick();
      checks++;
      if (obs_a !== 12'h000 || obs_b !== 12'h000) begin
        errors++;
        $display("FAIL reset_quiet cyc=%0d: a=%h b=%h expected 000", cyc, obs_a, obs_b);
      end
    end
    checks++;
    if (bus_a.tx_misalign_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d expected 0", bus_a.tx_misalign_cnt);
    end
  endtask

  // 16+2*extra idle cycles, then the even-slot K28.5 that opens PASS.
  // Leaves the block with the next slot odd.
  task automatic realign(input int extra);
    for (int i = 0; i < 16 + 2 * extra; i++) begin
      if (i % 2 == 0) begin
        if (i >= 16) drive(8'h00, 1'b0);
        else         drive(8'hBC, 1'b1);
        e0 = word(8'hBC, 1'b1, 1'b0, DISP_EN && (i == 0));
      end else begin
        drive(8'h50, 1'b0);
        e0 = word(8'h50, 1'b0, 1'b0, 1'b0);
      end
      tick();
      checks++;
      if (obs_a !== h2 || obs_b !== h1) begin
        errors++;
        $display("FAIL align_idle cyc=%0d i=%0d: a=%h b=%h expected a=%h b=%h", cyc, i, obs_a, obs_b, h2, h1);
      end
    end
    drive(8'hBC, 1'b1);
    e0 = word(8'hBC, 1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (obs_a !== h2 || obs_b !== h1) begin
      errors++;
      $display("FAIL pass_entry cyc=%0d: a=%h b=%h expected a=%h b=%h", cyc, obs_a, obs_b, h2, h1);
    end
  endtask

  task automatic test_align();
    bus_a.alt_tx_ready = 1'b1;
    drive(8'hBC, 1'b1);
    e0 = 12'h000;
    tick();
    realign(1);
    // Flush so the entry byte is visible at both outputs.
    drive(8'h50, 1'b0);
    e0 = word(8'h50, 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (obs_a !== word(8'hBC, 1'b1, 1'b1, 1'b0) || obs_b !== word(8'h50, 1'b0, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL first_pass_byte: a=%h b=%h", obs_a, obs_b);
    end
  endtask

  // Next slot is even on entry.
  task automatic test_latency();
    logic [7:0] seq [4];
    seq[0] = 8'h00; seq[1] = 8'hA5; seq[2] = 8'h00; seq[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      drive(seq[i], 1'b0);
      e0 = word(seq[i], 1'b0, 1'b1, 1'b0);
      tick();
      checks++;
      if (obs_a !== h2 || obs_b !== h1) begin
        errors++;
        $display("FAIL latency_seq cyc=%0d: a=%h b=%h expected a=%h b=%h", cyc, obs_a, obs_b, h2, h1);
      end
      if (i == 1) begin
        checks++;
        if (bus_b.alt_txdata !== 8'hA5 || bus_a.alt_txdata !== 8'h00) begin
          errors++;
          $display("FAIL lat_1cyc: b=%h a=%h expected b=a5 a=00", bus_b.alt_txdata, bus_a.alt_txdata);
        end
      end
      if (i == 2) begin
        checks++;
        if (bus_a.alt_txdata !== 8'hA5) begin
          errors++;
          $display("FAIL lat_2cyc: a=%h expected a5", bus_a.alt_txdata);
        end
      end
    end
  endtask

  // Next slot is even on entry: even BC passes, odd BC is a misalignment.
  task automatic test_misalign();
    drive(8'hBC, 1'b1);
    e0 = word(8'hBC, 1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (obs_a !== h2 || obs_b !== h1) begin
      errors++;
      $display("FAIL even_k_pass cyc=%0d: a=%h b=%h expected a=%h b=%h", cyc, obs_a, obs_b, h2, h1);
    end
    drive(8'hBC, 1'b1);
    e0 = word(8'h50, 1'b0, 1'b0, 1'b0);
    exp_cnt = 1;
    tick();
    checks++;
    if (obs_a !== h2 || obs_b !== h1 || bus_a.tx_misalign_cnt !== exp_cnt[7:0]) begin
      errors++;
      $display("FAIL misalign cyc=%0d: a=%h b=%h cnt=%0d expected a=%h b=%h cnt=%0d",
               cyc, obs_a, obs_b, bus_a.tx_misalign_cnt, h2, h1, exp_cnt);
    end
    realign(0);
  endtask

  // Next slot is odd on entry.
  task automatic test_ready_drop();
    drive(8'h3C, 1'b0);
    e0 = word(8'h3C, 1'b0, 1'b1, 1'b0);
    tick();
    bus_a.alt_tx_ready = 1'b0;
    drive(8'h77, 1'b0);
    e0 = word(8'h77, 1'b0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus_a.alt_tx_ready = 1'b1;
      drive(8'hBC, 1'b1);
      e0 = 12'h000;
      tick();
      checks++;
      if (obs_a !== h2 || obs_b !== h1) begin
        errors++;
        $display("FAIL ready_drop cyc=%0d i=%0d: a=%h b=%h expected a=%h b=%h", cyc, i, obs_a, obs_b, h2, h1);
      end
    end
    checks++;
    if (obs_a !== 12'h000 || bus_a.tx_aligned !== 1'b0) begin
      errors++;
      $display("FAIL ready_drop_quiet: a=%h expected 000", obs_a);
    end
    realign(0);
  endtask

  // Next slot is odd on entry; each iteration misaligns then retrains.
  task automatic test_saturation();
    for (int k = 0; k < 259; k++) begin
      drive(8'hBC, 1'b1);
      e0 = word(8'h50, 1'b0, 1'b0, 1'b0);
      if (exp_cnt < 255) exp_cnt++;
      tick();
      checks++;
      if (obs_a !== h2 || obs_b !== h1 || bus_a.tx_misalign_cnt !== exp_cnt[7:0]) begin
        errors++;
        $display("FAIL sat_misalign k=%0d: a=%h b=%h cnt=%0d expected a=%h b=%h cnt=%0d",
                 k, obs_a, obs_b, bus_a.tx_misalign_cnt, h2, h1, exp_cnt);
      end
      realign(0);
    end
    checks++;
    if (bus_a.tx_misalign_cnt !== 8'hFF || bus_b.tx_misalign_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL sat_final: a=%h b=%h expected ff", bus_a.tx_misalign_cnt, bus_b.tx_misalign_cnt);
    end
  endtask

  initial begin
    e0 = 12'h000;
    h1 = 12'h000;
    h2 = 12'h000;
    test_reset();
    test_align();
    test_latency();
    test_misalign();
    test_ready_drop();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
